// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE registers on the MMU bus, edge-captured source requests,
// lowest-index-first priority to the CPU. Define INTC_ACK_HANDSHAKE_EN to drive int_ack pulses.
module interrupt_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  int_req,
  output logic [4:0]  int_ack,
  input  logic        mem_enable,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] A,
  input  logic [7:0]  di,
  output logic [7:0]  dout,   // read data; "do" is a reserved word in SystemVerilog
  output logic        cpu_irq,
  output logic [7:0]  cpu_vector,
  input  logic        cpu_ack
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  logic [4:0] req_prev_reg;
  logic [4:0] if_reg;
  logic [4:0] if_next;
  logic [7:0] ie_reg;
  logic [7:0] ie_next;
  logic [7:0] dout_reg;
  logic [7:0] dout_next;

  logic       sel_if;
  logic       sel_ie;
  logic       wr_if;
  logic       wr_ie;
  logic       rd_if;
  logic       rd_ie;
  logic [4:0] set;
  logic [4:0] pend;
  logic [4:0] first;
  logic [4:0] seen_lower;
  logic [4:0] ack_clr;
  logic [7:0] vector_next;

  // Bus decode
  assign sel_if = mem_enable & (A == ADDR_IF);
  assign sel_ie = mem_enable & (A == ADDR_IE);
  assign wr_if  = sel_if & ~wr_n;
  assign wr_ie  = sel_ie & ~wr_n;
  assign rd_if  = sel_if & ~rd_n;
  assign rd_ie  = sel_ie & ~rd_n;

  assign set  = int_req & ~req_prev_reg;
  assign pend = if_reg & ie_reg[4:0];

  // One-hot of the lowest pending source: a bit wins only if no lower bit is pending
  assign seen_lower[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_prio
      if (gi > 0) begin : g_chain
        assign seen_lower[gi] = seen_lower[gi-1] | pend[gi-1];
      end
      assign first[gi] = pend[gi] & ~seen_lower[gi];
    end
  endgenerate

  assign ack_clr = cpu_ack ? first : 5'b0;

  always_comb begin
    vector_next = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if (first[i]) begin
        vector_next = 8'h40 + (8'(i) << 3);
      end
    end
  end

  assign cpu_irq    = |pend;
  assign cpu_vector = vector_next;

  // Hardware set has the final say over both CPU write and service clear
  always_comb begin
    if_next = ((wr_if ? di[4:0] : if_reg) & ~ack_clr) | set;
    ie_next = wr_ie ? di : ie_reg;
  end

  always_comb begin
    dout_next = 8'h00;
    if (rd_if) begin
      dout_next = {3'b111, if_reg};
    end else if (rd_ie) begin
      dout_next = ie_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_prev_reg <= 5'b0;
      if_reg       <= 5'b0;
      ie_reg       <= 8'h00;
      dout_reg     <= 8'h00;
    end else begin
      req_prev_reg <= int_req;
      if_reg       <= if_next;
      ie_reg       <= ie_next;
      dout_reg     <= dout_next;
    end
  end

  assign dout = dout_reg;

`ifdef INTC_ACK_HANDSHAKE_EN
  logic [4:0] int_ack_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      int_ack_reg <= 5'b0;
    end else begin
      int_ack_reg <= set;
    end
  end

  assign int_ack = int_ack_reg;
`else
  assign int_ack = 5'b0;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expectations queued at drive time, popped when observed.
// Expected int_ack pulses follow INTC_ACK_HANDSHAKE_EN.
module tb_interrupt_controller;

  logic        clock;
  logic        reset;
  logic [4:0]  int_req;
  logic [4:0]  int_ack;
  logic        mem_enable;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] A;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        cpu_irq;
  logic [7:0]  cpu_vector;
  logic        cpu_ack;

`ifdef INTC_ACK_HANDSHAKE_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  interrupt_controller dut (
    .clock      (clock),
    .reset      (reset),
    .int_req    (int_req),
    .int_ack    (int_ack),
    .mem_enable (mem_enable),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .A          (A),
    .di         (di),
    .dout       (dout),
    .cpu_irq    (cpu_irq),
    .cpu_vector (cpu_vector),
    .cpu_ack    (cpu_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  // Advance past the next rising edge; outputs are sampled and inputs driven here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    mem_enable = 1'b0;
    rd_n = 1'b1;
    wr_n = 1'b1;
    A = 16'h0000;
    di = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    mem_enable = 1'b1;
    wr_n = 1'b0;
    A = addr;
    di = data;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [15:0] addr);
    mem_enable = 1'b1;
    rd_n = 1'b0;
    A = addr;
    tick();
    bus_idle();
  endtask

  function automatic logic [7:0] ack_exp(input logic [4:0] bits);
    return ACK_EN ? {3'b000, bits} : 8'h00;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    int_req = 5'b0;
    cpu_ack = 1'b0;
    bus_idle();
    tick();
    tick();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL reset_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL reset_vector got %h want %h", cpu_vector, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reset_dout got %h want %h", dout, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if ({3'b0, int_ack} !== exp) $display("FAIL reset_ack got %h want %h", int_ack, exp); else pass_cnt++;
    reset = 1'b0;
    tick();
    exp_q.push_back(8'hE0);
    bus_read(16'hFF0F);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reset_if_read got %h want %h", dout, exp); else pass_cnt++;
    $display("reset: irq=%b vec=%h dout=%h", cpu_irq, cpu_vector, dout);
  endtask

  task automatic test_registers();
    bus_write(16'hFF0F, 8'hFF);
    exp_q.push_back(8'hFF);
    bus_read(16'hFF0F);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reg_if_ff got %h want %h", dout, exp); else pass_cnt++;
    exp_q.push_back(8'h00);
    tick();
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reg_dout_idle got %h want %h", dout, exp); else pass_cnt++;

    bus_write(16'hFF0F, 8'h00);
    exp_q.push_back(8'hE0);
    bus_read(16'hFF0F);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reg_if_00 got %h want %h", dout, exp); else pass_cnt++;

    bus_write(16'hFFFF, 8'hA5);
    exp_q.push_back(8'hA5);
    bus_read(16'hFFFF);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reg_ie_a5 got %h want %h", dout, exp); else pass_cnt++;

    // IE[4:0]=05 masks lcdc/serial but passes timer
    bus_write(16'hFF0F, 8'h0A);
    exp_q.push_back(8'h00);
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL reg_gate_masked got %h want %h", cpu_irq, exp); else pass_cnt++;
    bus_write(16'hFF0F, 8'h04);
    exp_q.push_back(8'h01); exp_q.push_back(8'h50);
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL reg_gate_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL reg_gate_vec got %h want %h", cpu_vector, exp); else pass_cnt++;

    // Back-to-back: mapped read then unmapped read
    exp_q.push_back(8'hE4); exp_q.push_back(8'h00);
    mem_enable = 1'b1; rd_n = 1'b0; A = 16'hFF0F;
    tick();
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reg_b2b_first got %h want %h", dout, exp); else pass_cnt++;
    A = 16'hFF10;
    tick();
    bus_idle();
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reg_unmapped got %h want %h", dout, exp); else pass_cnt++;

    // Read and write together: old value returned, write lands
    exp_q.push_back(8'hE4); exp_q.push_back(8'h00);
    mem_enable = 1'b1; rd_n = 1'b0; wr_n = 1'b0; A = 16'hFF0F; di = 8'h00;
    tick();
    bus_idle();
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL reg_rdwr_dout got %h want %h", dout, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL reg_rdwr_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    bus_write(16'hFFFF, 8'h00);
    $display("registers: ie/if exercised, last dout=%h", dout);
  endtask

  task automatic test_vblank();
    bus_write(16'hFFFF, 8'h01);
    int_req = 5'h01;
    exp_q.push_back(8'h01); exp_q.push_back(8'h40); exp_q.push_back(ack_exp(5'h01));
    tick();
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL vblank_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL vblank_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if ({3'b0, int_ack} !== exp) $display("FAIL vblank_ack_pulse got %h want %h", int_ack, exp); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      tick();
      exp = exp_q.pop_front(); total_cnt++;
      if ({3'b0, int_ack} !== exp) $display("FAIL vblank_ack_held%0d got %h want %h", i, int_ack, exp); else pass_cnt++;
    end
    int_req = 5'h00;
    tick();
    // Service it: a held request must not re-set IF afterwards
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'hE0);
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL vblank_serviced_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    bus_read(16'hFF0F);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL vblank_single_set got %h want %h", dout, exp); else pass_cnt++;
    $display("vblank: irq=%b vec=%h", cpu_irq, cpu_vector);
  endtask

  task automatic test_priority();
    bus_write(16'hFFFF, 8'h1F);
    int_req = 5'h10;
    tick();
    int_req = 5'h00;
    exp_q.push_back(8'h60);
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL prio_joypad_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    int_req = 5'h02;
    tick();
    int_req = 5'h00;
    exp_q.push_back(8'h48);
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL prio_lcdc_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    exp_q.push_back(8'h60); exp_q.push_back(8'hF0);
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL prio_after_ack_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    bus_read(16'hFF0F);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL prio_after_ack_if got %h want %h", dout, exp); else pass_cnt++;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL prio_empty_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL prio_empty_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    $display("priority: irq=%b vec=%h", cpu_irq, cpu_vector);
  endtask

  task automatic test_collision();
    bus_write(16'hFF0F, 8'h04);
    // CPU clears IF and acks timer while timer rises again: the set survives
    mem_enable = 1'b1; wr_n = 1'b0; A = 16'hFF0F; di = 8'h00;
    cpu_ack = 1'b1;
    int_req = 5'h04;
    exp_q.push_back(8'hE4); exp_q.push_back(8'h50);
    tick();
    bus_idle();
    cpu_ack = 1'b0;
    int_req = 5'h00;
    exp = exp_q.pop_front();
    bus_read(16'hFF0F);
    total_cnt++;
    if (dout !== exp) $display("FAIL collision_if got %h want %h", dout, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL collision_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    bus_write(16'hFF0F, 8'h00);
    $display("collision: vec=%h", cpu_vector);
  endtask

  task automatic test_masking();
    bus_write(16'hFFFF, 8'h00);
    bus_write(16'hFF0F, 8'h1F);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL mask_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL mask_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    exp_q.push_back(8'hFF);
    bus_read(16'hFF0F);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL mask_spurious_ack got %h want %h", dout, exp); else pass_cnt++;
    bus_write(16'hFFFF, 8'h08);
    exp_q.push_back(8'h01); exp_q.push_back(8'h58);
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL mask_open_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL mask_open_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    bus_write(16'hFF0F, 8'h00);
    bus_write(16'hFFFF, 8'h00);
    $display("masking: irq=%b vec=%h", cpu_irq, cpu_vector);
  endtask

  task automatic test_reset_mid();
    bus_write(16'hFFFF, 8'h02);
    int_req = 5'h02;
    exp_q.push_back(ack_exp(5'h02)); exp_q.push_back(8'h48);
    tick();
    exp = exp_q.pop_front(); total_cnt++;
    if ({3'b0, int_ack} !== exp) $display("FAIL rmid_ack_before got %h want %h", int_ack, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL rmid_vec_before got %h want %h", cpu_vector, exp); else pass_cnt++;
    reset = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    tick();
    exp = exp_q.pop_front(); total_cnt++;
    if ({3'b0, int_ack} !== exp) $display("FAIL rmid_ack_dropped got %h want %h", int_ack, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if ({7'b0, cpu_irq} !== exp) $display("FAIL rmid_irq got %h want %h", cpu_irq, exp); else pass_cnt++;
    exp = exp_q.pop_front(); total_cnt++;
    if (cpu_vector !== exp) $display("FAIL rmid_vec got %h want %h", cpu_vector, exp); else pass_cnt++;
    reset = 1'b0;
    exp_q.push_back(ack_exp(5'h02));
    tick();
    exp = exp_q.pop_front(); total_cnt++;
    if ({3'b0, int_ack} !== exp) $display("FAIL rmid_ack_again got %h want %h", int_ack, exp); else pass_cnt++;
    exp_q.push_back(8'hE2);
    bus_read(16'hFF0F);
    exp = exp_q.pop_front(); total_cnt++;
    if (dout !== exp) $display("FAIL rmid_if_recaptured got %h want %h", dout, exp); else pass_cnt++;
    int_req = 5'h00;
    tick();
    $display("reset_mid: ack=%h dout=%h", int_ack, dout);
  endtask

  initial begin
    test_reset();
    test_registers();
    test_vblank();
    test_priority();
    test_collision();
    test_masking();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
